// File: rtl/alu_iter_exec_if.sv
// Request/response bundle between the control path and the iterative ALU.
interface alu_iter_exec_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_start;
    logic [3:0]       i_alu_control;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_alu_result;
    logic             o_zero;

    // Control path side: issues requests, observes status and result
    modport master (
        output i_start, i_alu_control, i_a, i_b,
        input  o_busy, o_done, o_alu_result, o_zero
    );

    // ALU side
    modport slave (
        input  i_start, i_alu_control, i_a, i_b,
        output o_busy, o_done, o_alu_result, o_zero
    );
endinterface

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle add/sub/and/or, shifts on a one-bit-per-cycle
// shifter, with a start/busy/done handshake. All outputs are registered.
module alu_iter_exec #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic          i_clk,
    input logic          i_reset,
    alu_iter_exec_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1011;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           r_state;
    logic [3:0]       r_op;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic             r_fill;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic [SHW-1:0]   w_amt;
    logic             w_is_shift;
    logic [WIDTH-1:0] w_quick;
    logic [WIDTH-1:0] w_shifted;

    assign w_amt      = bus.i_b[SHW-1:0];
    assign w_is_shift = (bus.i_alu_control == OP_SLL) || (bus.i_alu_control == OP_SRL) ||
                        (bus.i_alu_control == OP_SRA);

    // Single-cycle result for the op being accepted; shifts here are only the by-0 case
    always_comb begin
        w_quick = '0;
        case (bus.i_alu_control)
            OP_ADD:                 w_quick = bus.i_a + bus.i_b;
            OP_SUB:                 w_quick = bus.i_a + ~bus.i_b + WIDTH'(1);
            OP_AND:                 w_quick = bus.i_a & bus.i_b;
            OP_OR:                  w_quick = bus.i_a | bus.i_b;
            OP_SLL, OP_SRL, OP_SRA: w_quick = bus.i_a;
            default:                w_quick = '0;
        endcase
    end

    // One-bit shift step of the accumulator for the latched shift op
    always_comb begin
        w_shifted = r_acc;
        case (r_op)
            OP_SLL:  w_shifted = {r_acc[WIDTH-2:0], 1'b0};
            OP_SRL:  w_shifted = {1'b0, r_acc[WIDTH-1:1]};
            OP_SRA:  w_shifted = {r_fill, r_acc[WIDTH-1:1]};
            default: w_shifted = r_acc;
        endcase
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_fill   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (bus.i_start) begin
                        r_op   <= bus.i_alu_control;
                        r_cnt  <= w_amt;
                        r_busy <= 1'b1;
                        if (w_is_shift && (w_amt != '0)) begin
                            r_acc   <= bus.i_a;
                            r_fill  <= bus.i_a[WIDTH-1];
                            r_state <= StShift;
                        end else begin
                            r_result <= w_quick;
                            r_zero   <= (w_quick == '0);
                            r_done   <= 1'b1;
                            r_state  <= StDone;
                        end
                    end
                end
                StShift: begin
                    r_acc <= w_shifted;
                    r_cnt <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_result <= w_shifted;
                        r_zero   <= (w_shifted == '0);
                        r_done   <= 1'b1;
                        r_state  <= StDone;
                    end
                end
                StDone: begin
                    // start seen here is dropped, not queued
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.o_busy       = r_busy;
    assign bus.o_done       = r_done;
    assign bus.o_alu_result = r_result;
    assign bus.o_zero       = r_zero;
endmodule

// File: tb/tb_alu_iter_exec.sv
// Scoreboard bench for alu_iter_exec: each accepted request pushes its expected
// result and latency; a monitor pops and compares on every done pulse.
module tb_alu_iter_exec;
    localparam int unsigned W = 32;

    typedef struct {
        string       tag;
        logic [31:0] res;
        int unsigned acc_cyc;
        int unsigned lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_reset;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_pushed = 0;
    int unsigned n_done = 0;
    exp_t        sb[$];

    alu_iter_exec_if #(.WIDTH(W)) u_if ();

    alu_iter_exec #(.WIDTH(W)) u_dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .bus     (u_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] code, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned n;
        n = int'(b[4:0]);
        case (code)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b1000: return a << n;
            4'b1001: return a >> n;
            4'b1011: return 32'($signed(a) >>> n);
            default: return 32'h0;
        endcase
    endfunction

    function automatic int unsigned model_lat(input logic [3:0] code, input logic [31:0] b);
        if ((code == 4'b1000 || code == 4'b1001 || code == 4'b1011) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!i_reset && u_if.o_done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_res"}, u_if.o_alu_result, e.res);
                check({e.tag, "_zero"}, 32'(u_if.o_zero), 32'(e.res == 32'h0));
                check({e.tag, "_lat"}, cyc - e.acc_cyc, e.lat);
            end
        end
    end

    task automatic push(input string tag, input logic [31:0] res, input int unsigned lat);
        exp_t e;
        e.tag = tag;
        e.res = res;
        e.acc_cyc = cyc;
        e.lat = lat;
        sb.push_back(e);
        n_pushed++;
    endtask

    task automatic drive(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        u_if.i_start       = 1'b1;
        u_if.i_alu_control = code;
        u_if.i_a           = a;
        u_if.i_b           = b;
    endtask

    // Checks the current negedge first, then steps; bounded
    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (u_if.o_done) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int unsigned lat);
        @(negedge clk);
        drive(code, a, b);
        push(tag, exp, lat);
        @(negedge clk);
        u_if.i_start = 1'b0;
        check({tag, "_busy_t1"}, 32'(u_if.o_busy), 32'd1);
        wait_done(tag);
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(u_if.o_busy), 32'd0);
    endtask

    initial begin
        logic [3:0] codes [7];
        codes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1011};
        i_reset = 1'b1;
        u_if.i_start = 1'b0;
        u_if.i_alu_control = 4'b0;
        u_if.i_a = '0;
        u_if.i_b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(u_if.o_busy), 32'd0);
        check("rst_done", 32'(u_if.o_done), 32'd0);
        check("rst_res", u_if.o_alu_result, 32'd0);
        check("rst_zero", 32'(u_if.o_zero), 32'd1);
        i_reset = 1'b0;

        do_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'h0, 1);
        do_op("sub", 4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
        do_op("and", 4'b0000, 32'hF0F0, 32'hFF00, 32'hF000, 1);
        do_op("or", 4'b0001, 32'hF0F0, 32'hFF00, 32'hFFF0, 1);
        do_op("sll5", 4'b1000, 32'd1, 32'd5, 32'h20, 6);
        do_op("srl31", 4'b1001, 32'h8000_0000, 32'd31, 32'h1, 32);
        do_op("sra31", 4'b1011, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32);
        do_op("sll_mask", 4'b1000, 32'd1, 32'h25, 32'h20, 6);
        do_op("sll0", 4'b1000, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        do_op("unknown", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1);

        // Start pulse while busy is dropped; operand change while busy has no effect
        @(negedge clk);
        drive(4'b1000, 32'd3, 32'd4);
        push("bi_sll", 32'h30, 5);
        @(negedge clk);
        u_if.i_start = 1'b0;
        @(negedge clk);
        drive(4'b0010, 32'd3, 32'd4);
        @(negedge clk);
        u_if.i_start = 1'b0;
        u_if.i_a = 32'hFFFF;
        u_if.i_alu_control = 4'b0001;
        wait_done("bi_sll");
        @(negedge clk);
        drive(4'b0010, 32'd3, 32'd4);
        push("bi_add", 32'd7, 1);
        @(negedge clk);
        u_if.i_start = 1'b0;
        wait_done("bi_add");
        @(negedge clk);

        // Reset in the 3rd shift cycle of srl by 10
        @(negedge clk);
        drive(4'b1001, 32'h8000_0000, 32'd10);
        @(negedge clk);
        u_if.i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(u_if.o_busy), 32'd0);
        check("abort_done", 32'(u_if.o_done), 32'd0);
        check("abort_res", u_if.o_alu_result, 32'd0);
        check("abort_zero", 32'(u_if.o_zero), 32'd1);
        i_reset = 1'b0;
        repeat (15) @(negedge clk);
        do_op("post_add", 4'b0010, 32'd2, 32'd2, 32'd4, 1);

        for (int i = 0; i < 8; i++) begin
            logic [3:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            c = codes[$urandom_range(6, 0)];
            a = $urandom;
            b = $urandom;
            do_op($sformatf("rnd%0d", i), c, a, b, model(c, a, b), model_lat(c, b));
        end

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("done_count", n_done, n_pushed);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
